// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE operand feeder: FSM states, default widths
// and the index-width helpers used to size the row counters.
package pe_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam int DW_DEF  = 16;
    localparam int PSW_DEF = 32;

    function automatic int n_windows(input int img, input int filt);
        return img - filt + 1;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Load ports, PE-side operand stream and status of one operand feeder.
// Handshake: a load beat transfers on the rising edge where valid && ready are both high;
// valid may rise without waiting for ready and ready never depends on valid.
interface pe_operand_feeder_if #(
    parameter int DW  = 16,
    parameter int PSW = 32
);
    logic              start;
    logic [DW-1:0]     w_in_val;
    logic              w_in_valid;
    logic              w_in_ready;
    logic [DW-1:0]     i_in_val;
    logic              i_in_valid;
    logic              i_in_ready;
    logic              hold;
    logic [DW-1:0]     image_val;
    logic              image_en;
    logic [DW-1:0]     weight_val;
    logic              weight_en;
    logic [PSW-1:0]    psum_in;
    logic              win_first;
    logic              win_last;
    logic              busy;
    logic              done;
    pe_pkg::state_t    fsm_state;

    modport master (
        input  start, w_in_val, w_in_valid, i_in_val, i_in_valid, hold,
        output w_in_ready, i_in_ready, image_val, image_en, weight_val, weight_en,
               psum_in, win_first, win_last, busy, done, fsm_state
    );

    modport slave (
        output start, w_in_val, w_in_valid, i_in_val, i_in_valid, hold,
        input  w_in_ready, i_in_ready, image_val, image_en, weight_val, weight_en,
               psum_in, win_first, win_last, busy, done, fsm_state
    );

endinterface

// File: rtl/pe_operand_feeder_row_spad.sv
// Register-file scratchpad holding one row: one synchronous write port and one
// combinational read port. Contents are not reset.
module row_spad
    import pe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW   = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_operand_feeder.sv
// Buffers one filter row and one image row, then streams the 1-D sliding-window
// operand pairs to a PE, one pair per non-held cycle, with registered outputs.
module pe_operand_feeder
    import pe_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int IMG_LEN  = 8,
    parameter int DW       = DW_DEF,
    parameter int PSW      = PSW_DEF
) (
    input  logic clk,
    input  logic rst,
    pe_operand_feeder_if.master bus
);

    localparam int NWIN = n_windows(IMG_LEN, FILT_LEN);
    localparam int WAW  = idx_w(FILT_LEN);
    localparam int IAW  = idx_w(IMG_LEN);
    localparam int OW   = idx_w(NWIN);
    localparam int WCW  = $clog2(FILT_LEN + 1);
    localparam int ICW  = $clog2(IMG_LEN + 1);

    state_t state, state_nx;

    logic [WCW-1:0] w_cnt;
    logic [ICW-1:0] i_cnt;
    logic [OW-1:0]  out_idx;
    logic [WAW-1:0] tap;

    logic w_ready, i_ready, w_fire, i_fire, w_full_nx, i_full_nx;
    logic issue, last_tap, last_win;
    logic [IAW-1:0] img_raddr;
    logic [DW-1:0]  w_rd, i_rd;

    assign w_ready  = (state == LOAD) && (w_cnt < WCW'(FILT_LEN));
    assign i_ready  = (state == LOAD) && (i_cnt < ICW'(IMG_LEN));
    assign w_fire   = w_ready && bus.w_in_valid;
    assign i_fire   = i_ready && bus.i_in_valid;
    // Full after this edge: lets the final beats and the move to RUN share one edge.
    assign w_full_nx = (w_cnt == WCW'(FILT_LEN)) || (w_fire && (w_cnt == WCW'(FILT_LEN - 1)));
    assign i_full_nx = (i_cnt == ICW'(IMG_LEN))  || (i_fire && (i_cnt == ICW'(IMG_LEN - 1)));

    assign issue    = (state == RUN) && !bus.hold;
    assign last_tap = (tap == WAW'(FILT_LEN - 1));
    assign last_win = (out_idx == OW'(NWIN - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    if (w_full_nx && i_full_nx) state_nx = RUN;
            RUN:     if (issue && last_tap && last_win) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            w_cnt   <= '0;
            i_cnt   <= '0;
            out_idx <= '0;
            tap     <= '0;
        end else begin
            if (w_fire) w_cnt <= w_cnt + 1'b1;
            if (i_fire) i_cnt <= i_cnt + 1'b1;
            if (issue) begin
                if (last_tap) begin
                    tap     <= '0;
                    out_idx <= last_win ? '0 : out_idx + 1'b1;
                end else begin
                    tap <= tap + 1'b1;
                end
            end
        end
    end

    assign img_raddr = IAW'(out_idx) + IAW'(tap);

    row_spad #(.DEPTH(FILT_LEN), .WIDTH(DW)) u_w_spad (
        .clk   (clk),
        .we    (w_fire),
        .waddr (w_cnt[WAW-1:0]),
        .wdata (bus.w_in_val),
        .raddr (tap),
        .rdata (w_rd)
    );

    row_spad #(.DEPTH(IMG_LEN), .WIDTH(DW)) u_i_spad (
        .clk   (clk),
        .we    (i_fire),
        .waddr (i_cnt[IAW-1:0]),
        .wdata (bus.i_in_val),
        .raddr (img_raddr),
        .rdata (i_rd)
    );

    // Operand values hold their last issued pair through hold cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.image_val  <= '0;
            bus.weight_val <= '0;
            bus.image_en   <= 1'b0;
            bus.weight_en  <= 1'b0;
            bus.win_first  <= 1'b0;
            bus.win_last   <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.image_en  <= issue;
            bus.weight_en <= issue;
            bus.win_first <= issue && (tap == '0);
            bus.win_last  <= issue && last_tap;
            bus.done      <= issue && last_tap && last_win;
            if (issue) begin
                bus.image_val  <= i_rd;
                bus.weight_val <= w_rd;
            end
        end
    end

    assign bus.psum_in    = '0;
    assign bus.w_in_ready = w_ready;
    assign bus.i_in_ready = i_ready;
    assign bus.busy       = (state != IDLE);
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: default 3x8 instance plus a 3x3 edge instance.
module tb_pe_operand_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_operand_feeder_if #(.DW(16), .PSW(32)) ifa ();
    pe_operand_feeder_if #(.DW(16), .PSW(32)) ifb ();

    pe_operand_feeder #(.FILT_LEN(3), .IMG_LEN(8), .DW(16), .PSW(32)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    pe_operand_feeder #(.FILT_LEN(3), .IMG_LEN(3), .DW(16), .PSW(32)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] wts [3];
    logic [15:0] img [8];
    int          sums [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    // Final weight and image beats are always presented in the same cycle.
    task automatic load_a(input int gappy);
        int  wi = 0;
        int  ii = 0;
        int  guard = 0;
        logic wv, iv;
        while ((wi < 3 || ii < 8) && guard < 200) begin
            guard++;
            if (wi < 2) wv = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            else        wv = (wi == 2) && (ii == 7);
            if (ii < 7) iv = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            else        iv = (ii == 7) && (wi == 2);
            ifa.w_in_valid = wv;
            ifa.w_in_val   = wts[(wi < 3) ? wi : 0];
            ifa.i_in_valid = iv;
            ifa.i_in_val   = img[(ii < 8) ? ii : 0];
            chk("w_in_ready_load", ifa.w_in_ready, (wi < 3));
            chk("i_in_ready_load", ifa.i_in_ready, (ii < 8));
            tick();
            if (wv) wi++;
            if (iv) ii++;
        end
        ifa.w_in_valid = 1'b0;
        ifa.i_in_valid = 1'b0;
        chk("w_in_ready_full", ifa.w_in_ready, 1'b0);
        chk("i_in_ready_full", ifa.i_in_ready, 1'b0);
        chk("busy_run_entry", ifa.busy, 1'b1);
        chk("en_run_entry", ifa.image_en, 1'b0);
    endtask

    task automatic collect(input int hold_after, input int hold_len, input int rst_after);
        int k = 0;
        int cyc = 0;
        int hold_rem = 0;
        int w, t;
        logic [15:0] last_i, last_w;
        for (int s = 0; s < 6; s++) sums[s] = 0;
        while (k < 18 && cyc < 100) begin
            tick();
            cyc++;
            if (hold_rem > 0) begin
                chk("hold_image_en", ifa.image_en, 1'b0);
                chk("hold_weight_en", ifa.weight_en, 1'b0);
                chk("hold_image_val", ifa.image_val, last_i);
                chk("hold_weight_val", ifa.weight_val, last_w);
                hold_rem--;
                if (hold_rem == 0) ifa.hold = 1'b0;
            end else begin
                w = k / 3;
                t = k % 3;
                chk("image_en", ifa.image_en, 1'b1);
                chk("weight_en", ifa.weight_en, 1'b1);
                chk("image_val", ifa.image_val, img[w + t]);
                chk("weight_val", ifa.weight_val, wts[t]);
                chk("win_first", ifa.win_first, (t == 0));
                chk("win_last", ifa.win_last, (t == 2));
                chk("psum_in", ifa.psum_in, 0);
                chk("done", ifa.done, (k == 17));
                chk("busy", ifa.busy, 1'b1);
                sums[w] += int'(ifa.image_val) * int'(ifa.weight_val);
                last_i = ifa.image_val;
                last_w = ifa.weight_val;
                k++;
                if (k == 2) ifa.start = 1'b0;
                if (k == hold_after) begin
                    ifa.hold = 1'b1;
                    hold_rem = hold_len;
                end
                if (k == rst_after) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk("rst_image_en", ifa.image_en, 1'b0);
                    chk("rst_done", ifa.done, 1'b0);
                    chk("rst_busy", ifa.busy, 1'b0);
                    chk("rst_image_val", ifa.image_val, 0);
                    chk("rst_weight_val", ifa.weight_val, 0);
                    chk("rst_win_first", ifa.win_first, 1'b0);
                    chk("rst_w_in_ready", ifa.w_in_ready, 1'b0);
                    tick();
                    chk("rst_stays_idle", ifa.busy, 1'b0);
                    return;
                end
            end
        end
        chk("pair_count", k, 18);
        tick();
        chk("post_image_en", ifa.image_en, 1'b0);
        chk("post_done", ifa.done, 1'b0);
        chk("post_busy", ifa.busy, 1'b0);
    endtask

    initial begin
        logic [15:0] wb [3];
        logic [15:0] ib [3];
        int sb;
        int exp_dot [6];

        ifa.start = 1'b0; ifa.w_in_val = '0; ifa.w_in_valid = 1'b0;
        ifa.i_in_val = '0; ifa.i_in_valid = 1'b0; ifa.hold = 1'b0;
        ifb.start = 1'b0; ifb.w_in_val = '0; ifb.w_in_valid = 1'b0;
        ifb.i_in_val = '0; ifb.i_in_valid = 1'b0; ifb.hold = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk("reset_image_en", ifa.image_en, 1'b0);
        chk("reset_weight_en", ifa.weight_en, 1'b0);
        chk("reset_w_in_ready", ifa.w_in_ready, 1'b0);
        chk("reset_i_in_ready", ifa.i_in_ready, 1'b0);
        chk("reset_busy", ifa.busy, 1'b0);
        chk("reset_done", ifa.done, 1'b0);
        chk("reset_image_val", ifa.image_val, 0);
        rst = 1'b0;
        tick();

        // Basic job: weights 1,2,3 over image 1..8.
        wts = '{16'd1, 16'd2, 16'd3};
        img = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_dot = '{14, 20, 26, 32, 38, 44};
        start_a();
        chk("load_w_in_ready", ifa.w_in_ready, 1'b1);
        load_a(0);
        collect(-1, 0, -1);
        for (int s = 0; s < 6; s++) chk("dot_basic", sums[s], exp_dot[s]);

        // Bursty load with start held high through LOAD and early RUN.
        start_a();
        ifa.start = 1'b1;
        load_a(1);
        collect(-1, 0, -1);
        for (int s = 0; s < 6; s++) chk("dot_bursty", sums[s], exp_dot[s]);

        // Three-cycle hold after the fourth pair.
        start_a();
        load_a(0);
        collect(4, 3, -1);
        for (int s = 0; s < 6; s++) chk("dot_hold", sums[s], exp_dot[s]);

        // Reset after seven pairs, then a fresh job.
        start_a();
        load_a(1);
        collect(-1, 0, 7);
        wts = '{16'd2, 16'd0, 16'd1};
        img = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0};
        start_a();
        load_a(0);
        collect(-1, 0, -1);
        chk("dot_reload_win0", sums[0], 13);
        chk("dot_reload_win1", sums[1], 10);

        // Edge instance: FILT_LEN = IMG_LEN = 3, single window.
        wb = '{16'd1, 16'd2, 16'd3};
        ib = '{16'd3, 16'd2, 16'd1};
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            ifb.w_in_valid = 1'b1; ifb.w_in_val = wb[b];
            ifb.i_in_valid = 1'b1; ifb.i_in_val = ib[b];
            chk("b_w_in_ready", ifb.w_in_ready, 1'b1);
            chk("b_i_in_ready", ifb.i_in_ready, 1'b1);
            tick();
        end
        ifb.w_in_valid = 1'b0;
        ifb.i_in_valid = 1'b0;
        chk("b_ready_full", ifb.w_in_ready, 1'b0);
        sb = 0;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk("b_image_en", ifb.image_en, 1'b1);
            chk("b_image_val", ifb.image_val, ib[p]);
            chk("b_weight_val", ifb.weight_val, wb[p]);
            chk("b_win_first", ifb.win_first, (p == 0));
            chk("b_win_last", ifb.win_last, (p == 2));
            chk("b_done", ifb.done, (p == 2));
            sb += int'(ifb.image_val) * int'(ifb.weight_val);
        end
        chk("b_dot", sb, 10);
        tick();
        chk("b_post_en", ifb.image_en, 1'b0);
        chk("b_post_done", ifb.done, 1'b0);
        chk("b_post_busy", ifb.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
